// File: rtl/serial_shift_unit.sv
// serial_shift_unit
//   Multi-cycle barrel-shift replacement: shifts a word left, logically right
//   or arithmetically right by up to STEP bits per clock until the requested
//   amount has been applied, then holds the result under a valid/ready
//   handshake.
//
//   state | meaning
//   ------+---------------------------------------------------------
//   IDLE  | waiting for a request, in_ready high
//   SHIFT | applying min(STEP, remaining) bits per edge
//   DONE  | result valid, waiting for out_ready
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   request present
//   in_ready   unit idle and able to accept a request
//   word       operand
//   shamt      shift amount
//   op         00 SLL, 10 SRL, 11 SRA, 01 pass-through
//   flush      synchronous abort, returns to IDLE
//   out_valid  result available
//   out_ready  consumer accepts result
//   result     shifted word
//   busy       high in SHIFT or DONE
module serial_shift_unit #(
  parameter  int XLEN    = 32,
  parameter  int STEP    = 1,
  localparam int SHAMT_W = $clog2(XLEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [XLEN-1:0]    word,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic [1:0]         op,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               busy
);

  if (STEP < 1 || STEP > XLEN || (STEP & (STEP - 1)) != 0) begin : g_bad_step
    $error("serial_shift_unit: STEP must be a power of two in 1..XLEN");
  end

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_NOP = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b11;

  // STEP may equal XLEN, which needs one bit more than a shift amount.
  localparam logic [SHAMT_W:0] STEP_V = STEP[SHAMT_W:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t             r_state;
  logic [XLEN-1:0]    r_result;
  logic [SHAMT_W-1:0] r_rem;
  logic [1:0]         r_op;
  logic               r_sign;

  logic [SHAMT_W-1:0] w_step;
  logic               w_last;
  logic               w_fill;
  logic [XLEN-1:0]    w_sll;
  logic [XLEN-1:0]    w_srx;
  logic [XLEN-1:0]    w_next;

  // Bits applied this edge: min(STEP, remaining). The result always fits in
  // SHAMT_W bits because it never exceeds remaining.
  assign w_step = ({1'b0, r_rem} < STEP_V) ? r_rem : STEP_V[SHAMT_W-1:0];
  assign w_last = ({1'b0, r_rem} <= STEP_V);

  // SRA fills from the sign of the original operand, captured at accept.
  assign w_fill = (r_op == OP_SRA) && r_sign;
  assign w_sll  = r_result << w_step;
  assign w_srx  = (r_result >> w_step) |
                  (w_fill ? ~({XLEN{1'b1}} >> w_step) : {XLEN{1'b0}});
  assign w_next = (r_op == OP_SLL) ? w_sll : w_srx;

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign result    = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_result <= '0;
      r_rem    <= '0;
      r_op     <= OP_SLL;
      r_sign   <= 1'b0;
    end else if (flush) begin
      // Abort wins over accept and the output handshake; result is kept.
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_result <= word;
            r_rem    <= shamt;
            r_op     <= op;
            r_sign   <= word[XLEN-1];
            if (shamt == '0 || op == OP_NOP) begin
              r_state <= S_DONE;
            end else begin
              r_state <= S_SHIFT;
            end
          end
        end
        S_SHIFT: begin
          r_result <= w_next;
          r_rem    <= r_rem - w_step;
          if (w_last) begin
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_unit.sv
module tb_serial_shift_unit;

  localparam int NCFG  = 7;
  localparam int CX [NCFG] = '{32, 32, 32, 32, 8, 8, 8};
  localparam int CS [NCFG] = '{1, 2, 8, 32, 1, 4, 8};
  localparam int NRAND = 1200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endfunction

  // Reference: plain single-step shift of the operand by the full amount.
  function automatic logic [63:0] ref_shift(int xl, logic [63:0] w_in, int sh, int o);
    logic [63:0] mask;
    logic [63:0] w;
    logic [63:0] r;
    mask = (64'd1 << xl) - 64'd1;
    w = w_in & mask;
    case (o)
      0: r = (w << sh) & mask;
      2: r = w >> sh;
      3: begin
        r = w >> sh;
        if (w[xl-1]) r = r | (mask & ~(mask >> sh));
      end
      default: r = w;
    endcase
    return r;
  endfunction

  // Edges from accept to out_valid visible.
  function automatic int ref_lat(int st, int sh, int o);
    if (sh == 0 || o == 1) return 1;
    return 1 + (sh + st - 1) / st;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int XL = CX[g];
    localparam int ST = CS[g];
    localparam int SW = $clog2(XL);

    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [XL-1:0] word;
    logic [SW-1:0] shamt;
    logic [1:0]    op;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [XL-1:0] result;
    logic          busy;

    serial_shift_unit #(.XLEN(XL), .STEP(ST)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .word      (word),
      .shamt     (shamt),
      .op        (op),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .busy      (busy)
    );

    logic [63:0] q_res [$];
    int          q_at  [$];
    bit          seen;
    logic [63:0] held;

    // Monitor: pops an expectation the first cycle out_valid is seen.
    initial begin
      seen = 0;
      held = '0;
      forever begin
        @(negedge clk);
        if (out_valid === 1'b1) begin
          if (!seen) begin
            if (q_res.size() == 0) begin
              chk($sformatf("c%0d_spurious_out_valid", g), 64'(out_valid), 64'd0);
            end else begin
              held = q_res.pop_front();
              chk($sformatf("c%0d_result", g), 64'(result), held);
              chk($sformatf("c%0d_latency_cycle", g), 64'(cyc), 64'(q_at.pop_front()));
            end
            seen = 1;
          end else begin
            chk($sformatf("c%0d_result_stable", g), 64'(result), held);
          end
          chk($sformatf("c%0d_in_ready_in_done", g), 64'(in_ready), 64'd0);
          chk($sformatf("c%0d_busy_in_done", g), 64'(busy), 64'd1);
        end else begin
          seen = 0;
        end
      end
    end

    task automatic chk_idle(string tag);
      chk($sformatf("c%0d_%s_out_valid", g, tag), 64'(out_valid), 64'd0);
      chk($sformatf("c%0d_%s_busy", g, tag), 64'(busy), 64'd0);
      chk($sformatf("c%0d_%s_in_ready", g, tag), 64'(in_ready), 64'd1);
    endtask

    // mode: 0 normal, 1 flush at abort_t, 2 rst pulse at abort_t,
    // 3 flush together with the request. bp < 0 random backpressure,
    // otherwise out_ready held low for bp cycles in DONE.
    // Called at negedge+2 with the DUT idle.
    task automatic run_op(logic [63:0] w, int sh, int o, int mode, int abort_t, int bp);
      logic [63:0] exp;
      int lat;
      int t;
      int bpc;
      bit fin;
      bit hs;
      exp = ref_shift(XL, w, sh, o);
      lat = ref_lat(ST, sh, o);
      chk($sformatf("c%0d_start_in_ready", g), 64'(in_ready), 64'd1);
      in_valid  = 1'b1;
      word      = XL'(w);
      shamt     = SW'(sh);
      op        = 2'(o);
      flush     = (mode == 3);
      out_ready = 1'($urandom_range(0, 1));
      if (mode == 3) begin
        @(negedge clk); #2;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk_idle("flush_on_accept");
        return;
      end
      q_res.push_back(exp);
      q_at.push_back(cyc + lat);
      t = 0; bpc = 0; fin = 0; hs = 0;
      while (!fin) begin
        @(negedge clk); #2;
        t++;
        if (hs) begin
          in_valid  = 1'b0;
          out_ready = 1'b0;
          fin = 1;
        end else if (t > lat + (bp > 0 ? bp : 0) + 40) begin
          n_checks++;
          n_fail++;
          $display("FAIL c%0d_timeout out_valid=%0b busy=%0b waited=%0d", g, out_valid, busy, t);
          rst = 1'b1; #1; rst = 1'b0;
          in_valid = 1'b0;
          q_res.delete();
          q_at.delete();
          fin = 1;
        end else if (mode == 1 && t == abort_t) begin
          flush    = 1'b1;
          in_valid = 1'($urandom);
          @(negedge clk); #2;
          flush    = 1'b0;
          in_valid = 1'b0;
          chk_idle("after_flush");
          if (abort_t >= lat) begin
            chk($sformatf("c%0d_result_kept_after_flush", g), 64'(result), exp);
          end else begin
            void'(q_res.pop_back());
            void'(q_at.pop_back());
          end
          fin = 1;
        end else if (mode == 2 && t == abort_t) begin
          rst = 1'b1;
          #1;
          chk_idle("in_reset");
          chk($sformatf("c%0d_in_reset_result", g), 64'(result), 64'd0);
          @(negedge clk); #2;
          rst      = 1'b0;
          in_valid = 1'b0;
          if (abort_t < lat) begin
            void'(q_res.pop_back());
            void'(q_at.pop_back());
          end
          fin = 1;
        end else begin
          // Junk on the request side while busy must be ignored.
          in_valid = 1'($urandom);
          word     = XL'({$urandom, $urandom});
          shamt    = SW'($urandom);
          op       = 2'($urandom);
          if (out_valid === 1'b1) begin
            if (mode != 0)    out_ready = 1'b0;
            else if (bp >= 0) out_ready = (bpc >= bp);
            else              out_ready = ($urandom_range(0, 2) != 0);
            bpc++;
            if (out_ready) hs = 1;
          end else begin
            out_ready = 1'($urandom_range(0, 1));
          end
        end
      end
    endtask

    initial begin
      int r;
      int sh;
      int o;
      int md;
      int ab;
      rst = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
      word = '0; shamt = '0; op = 2'b00;
      #1 rst = 1'b1;
      #1;
      chk_idle("reset");
      chk($sformatf("c%0d_reset_result", g), 64'(result), 64'd0);
      @(negedge clk); #2;
      rst = 1'b0;
      // First request goes in on the first edge after release.
      run_op(64'h8000_0000, 4, 3, 0, 0, -1);
      run_op(64'h0000_0001, XL - 1, 0, 0, 0, -1);
      run_op(64'hF000_0000, 28 % XL, 2, 0, 0, -1);
      run_op(64'hDEAD_BEEF, 0, 2, 0, 0, -1);
      run_op(64'hDEAD_BEEF, 7, 1, 0, 0, -1);
      run_op(64'h1234_5678, 5, 0, 0, 0, 3);
      run_op(64'h000A_BCDE, 20 % XL, 0, 1, 5, -1);
      run_op(64'h0000_0003, 2, 0, 0, 0, -1);
      run_op(64'h89AB_CDEF, XL - 1, 3, 2, 3, -1);
      run_op(64'h0000_0005, 1, 0, 3, 0, -1);
      run_op(64'hFFFF_FFFF, XL - 1, 3, 0, 0, 0);
      for (int i = 0; i < NRAND; i++) begin
        r  = $urandom_range(0, 19);
        md = (r < 16) ? 0 : (r < 18) ? 1 : (r == 18) ? 2 : 3;
        sh = $urandom_range(0, XL - 1);
        o  = $urandom_range(0, 3);
        ab = $urandom_range(1, ref_lat(ST, sh, o) + 1);
        run_op({$urandom, $urandom}, sh, o, md, ab, -1);
      end
      repeat (3) @(negedge clk);
      chk($sformatf("c%0d_scoreboard_drained", g), 64'(q_res.size()), 64'd0);
      n_done++;
    end
  end

  initial begin
    for (int i = 0; i < 90000 && n_done < NCFG; i++) @(posedge clk);
    if (n_done < NCFG) begin
      n_checks++;
      n_fail++;
      $display("FAIL watchdog configs_done=%0d required=%0d", n_done, NCFG);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_shift_unit.md
SERIAL_SHIFT_UNIT -- requirements
Module: serial_shift_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, data word width.
REQ-002 SHALL have parameter STEP, default 1, maximum shift bits applied per cycle; power of two, 1..XLEN, else elaboration error.
REQ-003 SHALL derive localparam SHAMT_W = clog2(XLEN), shift amount width.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  request present.
REQ-007 in_ready  output  1  unit can accept a request.
REQ-008 word  input  XLEN  operand to shift.
REQ-009 shamt  input  SHAMT_W  shift amount.
REQ-010 op  input  2  00 SLL, 10 SRL, 11 SRA, 01 undefined.
REQ-011 flush  input  1  synchronous abort of any in-flight operation.
REQ-012 out_valid  output  1  result available.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 result  output  XLEN  shifted word.
REQ-015 busy  output  1  high in SHIFT or DONE.

Function
REQ-016 SHALL implement states IDLE, SHIFT, DONE; in_ready = (state==IDLE), combinational.
REQ-017 Accept = in_valid && in_ready && !flush; on accept edge SHALL latch word into result register, shamt into remaining counter, op into op register.
REQ-018 On accept with shamt==0 or op==01, SHALL go directly to DONE with result = word unchanged.
REQ-019 Otherwise SHALL go to SHIFT; each SHIFT edge applies s = min(STEP, remaining) bits and decrements remaining by s.
REQ-020 SHIFT -> DONE on the edge where remaining == s (last step); total edges from accept to out_valid high = 1 + ceil(shamt/STEP).
REQ-021 SLL fills zeros at LSB; SRL fills zeros at MSB; SRA fills with word[XLEN-1] of the original operand on every step.
REQ-022 Final result SHALL equal single-cycle shift of word by shamt for all ops, XLEN, STEP.
REQ-023 out_valid = (state==DONE); result SHALL be held stable while out_valid && !out_ready.
REQ-024 DONE -> IDLE on edge with out_ready high; no new request accepted in that edge (in_ready low in DONE).
REQ-025 in_valid, word, shamt, op SHALL be ignored outside IDLE.
REQ-026 flush high on an edge SHALL force state IDLE regardless of state; overrides accept and DONE handshake; result register retains value, out_valid low next cycle.
REQ-027 shamt = XLEN-1 SHALL complete without counter wrap; remaining never underflows.

Reset
REQ-028 rst asserted SHALL immediately force state IDLE, result 0, remaining 0, op register 00.
REQ-029 During and after reset: out_valid 0, busy 0, in_ready 1.
REQ-030 Reset asserted mid-SHIFT or in DONE SHALL discard the operation; no out_valid pulse after release.
REQ-031 First request accepted on the first rising edge after rst deasserts.

Verification
REQ-032 XLEN=32 STEP=1: SRA word 0x80000000 shamt 4 -> result 0xF8000000, out_valid high 5 edges after accept edge inclusive.
REQ-033 XLEN=32 STEP=8: SLL word 0x00000001 shamt 31 -> result 0x80000000, out_valid after 1+4 edges; SRL 0xF0000000 shamt 28 -> 0x0000000F.
REQ-034 shamt 0 SRL word 0xDEADBEEF, and op 01 shamt 7 -> result 0xDEADBEEF, out_valid after 1 edge.
REQ-035 Backpressure: out_ready low 3 cycles in DONE -> result stable, in_ready low, in_valid ignored; out_ready high -> IDLE next edge, in_ready 1.
REQ-036 flush asserted mid-SHIFT (STEP=1, shamt 20, 5th cycle) -> IDLE next edge, out_valid never rises; next request SLL 0x3 by 2 -> 0x0000000C.
REQ-037 Random: XLEN in {8,32}, STEP in {1,2,4,XLEN}, 10k ops vs reference shift; async rst pulses mid-operation -> outputs zeroed same cycle, no spurious out_valid.
